baby_store: RTL and testbench
=============================

# baby_store

Program store and loader for the Manchester Baby core: a 32 × 32-bit word store that the core reads and writes over its bidirectional RAM bus. A byte-wide load/dump port fills the store before a run and reads it back afterwards. The block holds the core in reset while loading or dumping, and stops the run when the core's stop lamp lights. It sits directly on the core's `ram_*` pins, in place of an external memory.

## Interface
- `RESET_CYCLES`, default 2: clocks `core_reset_o` stays high after entering RUN (min 1).
- `AUTO_RUN`, default 1: 1 = completed LOAD goes straight to RUN; 0 = returns to IDLE.
- `clock` in 1: system clock, same clock that drives the core.
- `reset_ni` in 1: asynchronous, active-low reset.
- `load_start_i` in 1: one-cycle request to begin LOAD.
- `run_start_i` in 1: one-cycle request to begin RUN.
- `dump_start_i` in 1: one-cycle request to begin DUMP.
- `load_valid_i` in 1 / `load_ready_o` out 1 / `load_byte_i` in 8: load byte stream.
- `dump_valid_o` out 1 / `dump_ready_i` in 1 / `dump_byte_o` out 8: dump byte stream.
- `core_clk_i` in 1: core's clock-tree output (`logisim_clock_tree_0_out`).
- `core_addr_i` in 5: core `ram_addr_o`.
- `core_rw_en_i` in 1: core `ram_rw_en_o`, 1 = write.
- `core_data_io` inout 32: core `ram_data_io`.
- `stop_lamp_i` in 1: core `stop_lamp_o`.
- `core_reset_o` out 1: drives core `reset_i`, active-high.
- `running_o` out 1 / `halted_o` out 1: status.

## Operation
- States: IDLE, LOAD, RUN, HALTED, DUMP.
- Start requests are honoured only in IDLE and HALTED; ignored elsewhere. Simultaneous requests resolve by priority load > dump > run.
- Byte counter `cnt` is 7 bits. Byte k maps to word k[6:2], bits 8·k[1:0]+7 : 8·k[1:0] (little-endian within each word, word 0 first).
- **LOAD:**
  - `load_ready_o` = 1.
  - Each cycle with `load_valid_i & load_ready_o`, write one byte into the store and increment `cnt`.
  - After byte 127, go to RUN if `AUTO_RUN`, else IDLE.
  - `cnt` clears on entry to LOAD.
- **DUMP:**
  - `dump_byte_o` is byte `cnt` of the store; `dump_valid_o` = 1.
  - Advance on `dump_valid_o & dump_ready_i`.
  - After byte 127 is accepted, go to IDLE.
  - `dump_byte_o` stays stable while stalled.
- **RUN:**
  - `running_o` = 1.
  - `core_reset_o` = 1 for the first `RESET_CYCLES` clocks, then 0.
  - Edge detect: `ce = core_clk_i & ~core_clk_q`. Accesses are enabled only when `core_reset_o` = 0.
  - On `ce` with `core_rw_en_i` = 0: `rd_q` <= `mem[core_addr_i]`.
  - On `ce` with `core_rw_en_i` = 1: `mem[core_addr_i]` <= `core_data_io`.
  - `core_data_io` is driven with `rd_q` when in RUN and `core_rw_en_i` = 0; otherwise high-Z.
  - `stop_lamp_i` = 1 moves to HALTED. An access on the same cycle still completes.
- **HALTED:** `halted_o` = 1 and `core_reset_o` = 1. Store contents are retained.
- **Outside RUN:** `core_reset_o` = 1 and `core_data_io` is high-Z.
- **Store reset:** the store array has no reset; contents survive `reset_ni`.

## Timing
- Reset values:
  - state IDLE, `cnt` 0, `rd_q` 0, `core_clk_q` 0
  - `core_reset_o` 1, `load_ready_o` 0, `dump_valid_o` 0, `dump_byte_o` 0
  - `running_o` 0, `halted_o` 0, `core_data_io` high-Z
- Reset asserted mid-LOAD or mid-DUMP aborts immediately; partially loaded words keep the bytes already written.
- A start request registered at edge N takes effect from edge N+1 (state visible after N).
- LOAD throughput: 1 byte/clock, 128 clocks minimum. DUMP is the same: 1 byte/clock when `dump_ready_i` is held high.
- Read latency: `rd_q` (and `core_data_io`) updates on the clock edge following the cycle in which `ce` is seen, i.e. one clock after the `core_clk_i` rise is sampled.
- Write commits on the same edge.
- `core_reset_o` falls `RESET_CYCLES` clocks after RUN entry.
- HALTED is reached one clock after `stop_lamp_i` is sampled high.

## Test plan
- **Load/dump round trip:** LOAD 128 bytes encoding words `0x00000013, 0x0000401f, …, 0x00000024` -> DUMP returns the identical byte sequence, starting `13 00 00 00 1f 40 00 00`.
- **Core read:** with `AUTO_RUN` = 1, after load `core_reset_o` falls 2 clocks into RUN. A core read of addr 0x01 sees `core_data_io` = `0x0000401f` one clock after the `core_clk_i` rise.
- **Core write and halt:** core writes `0x12345678` to addr 0x1c, then `stop_lamp_i` rises -> `halted_o` = 1 next clock and `core_reset_o` = 1. DUMP bytes 112..115 = `78 56 34 12`.
- **Dump backpressure:** `dump_ready_i` toggled 1/0 every clock -> 128 bytes delivered in order, and `dump_byte_o` is stable during stalls.
- **Mid-load reset:** `reset_ni` low after 10 loaded bytes -> all outputs return to reset values and state is IDLE. A subsequent DUMP shows the 10 new bytes, with the old content beyond them.
- **Ignored requests:** `run_start_i` and `dump_start_i` pulsed during LOAD are ignored. `load_start_i` and `dump_start_i` asserted together in IDLE -> LOAD is entered.

Source files
------------

// File: rtl/baby_store_if.sv
// Host-side handshake bundle for baby_store: the three start requests and the
// byte-wide load and dump streams. The store takes the slave side; whatever
// fills and empties it (loader, test bench) takes the master side.
interface baby_store_if;
    logic       load_start_i;
    logic       run_start_i;
    logic       dump_start_i;

    logic       load_valid_i;
    logic       load_ready_o;
    logic [7:0] load_byte_i;

    logic       dump_valid_o;
    logic       dump_ready_i;
    logic [7:0] dump_byte_o;

    modport slave (
        input  load_start_i,
        input  run_start_i,
        input  dump_start_i,
        input  load_valid_i,
        input  load_byte_i,
        input  dump_ready_i,
        output load_ready_o,
        output dump_valid_o,
        output dump_byte_o
    );

    modport master (
        output load_start_i,
        output run_start_i,
        output dump_start_i,
        output load_valid_i,
        output load_byte_i,
        output dump_ready_i,
        input  load_ready_o,
        input  dump_valid_o,
        input  dump_byte_o
    );
endinterface

// File: rtl/baby_store.sv
// Program store and loader for the Manchester Baby core. Holds 32 x 32-bit
// words, serves the core's bidirectional RAM bus while running, and exposes a
// byte-wide load/dump port (byte k = word k[6:2], little-endian within a word)
// for filling the store before a run and reading it back afterwards.
module baby_store #(
    parameter int RESET_CYCLES = 2,     // clocks core_reset_o stays high in RUN (>= 1)
    parameter bit AUTO_RUN     = 1'b1   // completed LOAD goes straight to RUN
) (
    input  logic        clock,
    input  logic        reset_ni,
    baby_store_if.slave host,
    input  logic        core_clk_i,
    input  logic [4:0]  core_addr_i,
    input  logic        core_rw_en_i,
    inout  wire  [31:0] core_data_io,
    input  logic        stop_lamp_i,
    output logic        core_reset_o,
    output logic        running_o,
    output logic        halted_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_HALTED,
        ST_DUMP
    } state_e;

    localparam int            RCW      = $clog2(RESET_CYCLES + 1);
    localparam logic [RCW-1:0] RST_LAST = RCW'(RESET_CYCLES);
    localparam logic [6:0]     LAST_BYTE = 7'd127;

    state_e           state_q, state_d;
    logic [6:0]       cnt_q, cnt_d;
    logic [RCW-1:0]   rst_cnt_q, rst_cnt_d;
    logic             core_clk_q;
    logic [31:0]      rd_q;
    logic [31:0]      mem [32];

    logic             in_run;
    logic             core_live;
    logic             ce;
    logic             core_wr;
    logic             core_rd;
    logic             load_fire;
    logic             dump_fire;
    logic [31:0]      dump_word;

    // Core bus qualification: accesses only once the core is out of reset.
    assign in_run    = (state_q == ST_RUN);
    assign core_live = in_run && (rst_cnt_q == RST_LAST);
    assign ce        = core_clk_i & ~core_clk_q;
    assign core_wr   = core_live & ce & core_rw_en_i;
    assign core_rd   = core_live & ce & ~core_rw_en_i;

    // Byte stream handshakes; ready/valid are pure functions of state.
    assign load_fire = (state_q == ST_LOAD) && host.load_valid_i;
    assign dump_fire = (state_q == ST_DUMP) && host.dump_ready_i;

    // Next-state and counter logic for the load/run/dump sequencer.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        rst_cnt_d = rst_cnt_q;

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (host.load_start_i) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end else if (host.dump_start_i) begin
                    state_d = ST_DUMP;
                    cnt_d   = '0;
                end else if (host.run_start_i) begin
                    state_d   = ST_RUN;
                    rst_cnt_d = '0;
                end
            end

            ST_LOAD: begin
                if (load_fire) begin
                    cnt_d = cnt_q + 7'd1;
                    if (cnt_q == LAST_BYTE) begin
                        state_d   = AUTO_RUN ? ST_RUN : ST_IDLE;
                        rst_cnt_d = '0;
                    end
                end
            end

            ST_RUN: begin
                if (rst_cnt_q != RST_LAST) begin
                    rst_cnt_d = rst_cnt_q + RCW'(1);
                end
                if (stop_lamp_i) begin
                    state_d = ST_HALTED;
                end
            end

            ST_DUMP: begin
                if (dump_fire) begin
                    cnt_d = cnt_q + 7'd1;
                    if (cnt_q == LAST_BYTE) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer registers, core clock edge detector and read-data register.
    always_ff @(posedge clock or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rst_cnt_q  <= '0;
            core_clk_q <= 1'b0;
            rd_q       <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples values from before this edge.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rst_cnt_q  <= rst_cnt_d;
            core_clk_q <= core_clk_i;
            if (core_rd) begin
                rd_q <= mem[core_addr_i];
            end
        end
    end

    // Store write port: byte writes from the loader, word writes from the core.
    // NOTE: the array deliberately has no reset, so a program survives reset_ni
    // and a reset mid-load keeps the bytes already written.
    always_ff @(posedge clock) begin
        if (load_fire) begin
            mem[cnt_q[6:2]][{cnt_q[1:0], 3'b000} +: 8] <= host.load_byte_i;
        end else if (core_wr) begin
            mem[core_addr_i] <= core_data_io;
        end
    end

    // Dump stream: byte cnt_q of the store; stable while stalled since neither
    // cnt_q nor the store changes in DUMP without an accepted byte.
    assign dump_word         = mem[cnt_q[6:2]];
    assign host.dump_valid_o = (state_q == ST_DUMP);
    assign host.dump_byte_o  = host.dump_valid_o ? dump_word[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;
    assign host.load_ready_o = (state_q == ST_LOAD);

    // Core-facing outputs: the core is held in reset except in RUN after the
    // reset window, and the store only drives the bus for core reads.
    assign core_reset_o = ~core_live;
    assign core_data_io = (in_run && !core_rw_en_i) ? rd_q : 32'bz;
    assign running_o    = in_run;
    assign halted_o     = (state_q == ST_HALTED);

endmodule

// File: tb/tb_baby_store.sv
// Directed bench for baby_store: load/dump round trip, core read/write over
// the tristate bus, halt, dump backpressure, mid-load reset, ignored requests.
module tb_baby_store;

    logic        clock;
    logic        reset_ni;
    logic        core_clk_i;
    logic [4:0]  core_addr;
    logic        core_rw;
    logic        tb_drive;
    logic [31:0] tb_wdata;
    wire  [31:0] core_data;
    logic        stop_lamp;
    logic        core_reset;
    logic        running;
    logic        halted;

    baby_store_if bus ();

    assign core_data = tb_drive ? tb_wdata : 32'bz;

    baby_store #(.RESET_CYCLES(2), .AUTO_RUN(1'b1)) dut (
        .clock        (clock),
        .reset_ni     (reset_ni),
        .host         (bus),
        .core_clk_i   (core_clk_i),
        .core_addr_i  (core_addr),
        .core_rw_en_i (core_rw),
        .core_data_io (core_data),
        .stop_lamp_i  (stop_lamp),
        .core_reset_o (core_reset),
        .running_o    (running),
        .halted_o     (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] golden  [32];
    logic [7:0]  src     [128];
    logic [7:0]  exp_mem [128];
    logic [7:0]  got     [128];

    task automatic step();
        @(negedge clock);
    endtask

    task automatic pulse_start(input bit ld, input bit dp, input bit rn);
        bus.load_start_i = ld;
        bus.dump_start_i = dp;
        bus.run_start_i  = rn;
        step();
        bus.load_start_i = 1'b0;
        bus.dump_start_i = 1'b0;
        bus.run_start_i  = 1'b0;
    endtask

    task automatic load_bytes(input int n);
        for (int k = 0; k < n; k++) begin
            bus.load_valid_i = 1'b1;
            bus.load_byte_i  = src[k];
            step();
            exp_mem[k] = src[k];
        end
        bus.load_valid_i = 1'b0;
        bus.load_byte_i  = 8'h00;
    endtask

    // Collects up to 128 dump bytes into got[]; counts bytes that changed while stalled.
    task automatic run_dump(input bit toggle, output int unstable, output bit timeout, output int cycles);
        int         idx;
        bit         prev_stall;
        logic [7:0] prev_byte;
        bit         rdy;
        idx = 0; prev_stall = 1'b0; prev_byte = 8'h00; unstable = 0; cycles = 0;
        while (idx < 128 && cycles < 600) begin
            rdy = toggle ? (cycles % 2 == 0) : 1'b1;
            bus.dump_ready_i = rdy;
            if (prev_stall && bus.dump_byte_o !== prev_byte) unstable++;
            if (bus.dump_valid_o === 1'b1 && rdy) begin
                got[idx] = bus.dump_byte_o;
                idx++;
            end
            prev_stall = (bus.dump_valid_o === 1'b1) && !rdy;
            prev_byte  = bus.dump_byte_o;
            step();
            cycles++;
        end
        bus.dump_ready_i = 1'b0;
        timeout = (idx < 128);
    endtask

    task automatic core_access(input logic [4:0] a, input bit wr, input logic [31:0] d, input bit stop);
        core_clk_i = 1'b0;
        step();
        core_addr  = a;
        core_rw    = wr;
        tb_drive   = wr;
        tb_wdata   = d;
        stop_lamp  = stop;
        core_clk_i = 1'b1;
        step();
        stop_lamp  = 1'b0;
        tb_drive   = 1'b0;
        core_rw    = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        tests_run++; if (core_reset !== 1'b1) begin tests_failed++; $display("FAIL reset_core_reset: got %b expected 1", core_reset); end
        tests_run++; if (bus.load_ready_o !== 1'b0) begin tests_failed++; $display("FAIL reset_load_ready: got %b expected 0", bus.load_ready_o); end
        tests_run++; if (bus.dump_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_dump_valid: got %b expected 0", bus.dump_valid_o); end
        tests_run++; if (bus.dump_byte_o !== 8'h00) begin tests_failed++; $display("FAIL reset_dump_byte: got %h expected 00", bus.dump_byte_o); end
        tests_run++; if (running !== 1'b0 || halted !== 1'b0) begin tests_failed++; $display("FAIL reset_status: got run=%b halt=%b expected 0 0", running, halted); end
        reset_ni = 1'b1;
        step();
    endtask

    task automatic test_load_dump_roundtrip();
        int         unstable, cycles;
        bit         timeout;
        logic [7:0] first8 [8];
        first8 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h1f, 8'h40, 8'h00, 8'h00};
        for (int w = 0; w < 32; w++)
            for (int j = 0; j < 4; j++) src[4*w+j] = golden[w][8*j +: 8];
        pulse_start(1'b1, 1'b0, 1'b0);
        tests_run++; if (bus.load_ready_o !== 1'b1) begin tests_failed++; $display("FAIL load_ready: got %b expected 1", bus.load_ready_o); end
        load_bytes(128);
        tests_run++; if (running !== 1'b1 || bus.load_ready_o !== 1'b0) begin tests_failed++; $display("FAIL auto_run: got run=%b ready=%b expected 1 0", running, bus.load_ready_o); end
        tests_run++; if (core_reset !== 1'b1) begin tests_failed++; $display("FAIL run_reset_c0: got %b expected 1", core_reset); end
        step();
        tests_run++; if (core_reset !== 1'b1) begin tests_failed++; $display("FAIL run_reset_c1: got %b expected 1", core_reset); end
        step();
        tests_run++; if (core_reset !== 1'b0) begin tests_failed++; $display("FAIL run_reset_c2: got %b expected 0", core_reset); end
        stop_lamp = 1'b1;
        step();
        stop_lamp = 1'b0;
        tests_run++; if (halted !== 1'b1 || core_reset !== 1'b1) begin tests_failed++; $display("FAIL halt1: got halt=%b rst=%b expected 1 1", halted, core_reset); end
        pulse_start(1'b0, 1'b1, 1'b0);
        run_dump(1'b0, unstable, timeout, cycles);
        tests_run++; if (timeout !== 1'b0 || cycles != 128) begin tests_failed++; $display("FAIL rt_dump_len: got timeout=%b cycles=%0d expected 0 128", timeout, cycles); end
        for (int k = 0; k < 8; k++) begin
            tests_run++; if (got[k] !== first8[k]) begin tests_failed++; $display("FAIL rt_first8[%0d]: got %h expected %h", k, got[k], first8[k]); end
        end
        for (int k = 0; k < 128; k++) begin
            tests_run++; if (got[k] !== exp_mem[k]) begin tests_failed++; $display("FAIL rt_byte[%0d]: got %h expected %h", k, got[k], exp_mem[k]); end
        end
        tests_run++; if (bus.dump_valid_o !== 1'b0) begin tests_failed++; $display("FAIL rt_dump_end: got valid=%b expected 0", bus.dump_valid_o); end
    endtask

    task automatic test_core_read();
        pulse_start(1'b0, 1'b0, 1'b1);
        tests_run++; if (running !== 1'b1 || core_reset !== 1'b1) begin tests_failed++; $display("FAIL rd_run_entry: got run=%b rst=%b expected 1 1", running, core_reset); end
        step();
        step();
        tests_run++; if (core_reset !== 1'b0) begin tests_failed++; $display("FAIL rd_reset_fall: got %b expected 0", core_reset); end
        core_access(5'h01, 1'b0, 32'h0, 1'b0);
        tests_run++; if (core_data !== 32'h0000401f) begin tests_failed++; $display("FAIL rd_addr1: got %h expected 0000401f", core_data); end
        core_addr = 5'h02;
        step();
        tests_run++; if (core_data !== 32'h0000401f) begin tests_failed++; $display("FAIL rd_no_edge: got %h expected 0000401f", core_data); end
        core_access(5'h02, 1'b0, 32'h0, 1'b0);
        tests_run++; if (core_data !== golden[2]) begin tests_failed++; $display("FAIL rd_addr2: got %h expected %h", core_data, golden[2]); end
    endtask

    task automatic test_core_write_halt();
        int         unstable, cycles;
        bit         timeout;
        logic [7:0] tail [4];
        tail = '{8'h78, 8'h56, 8'h34, 8'h12};
        core_access(5'h1c, 1'b1, 32'h12345678, 1'b0);
        core_access(5'h1c, 1'b0, 32'h0, 1'b0);
        tests_run++; if (core_data !== 32'h12345678) begin tests_failed++; $display("FAIL wr_readback: got %h expected 12345678", core_data); end
        core_access(5'h1d, 1'b1, 32'hcafef00d, 1'b1);
        core_clk_i = 1'b0;
        tests_run++; if (halted !== 1'b1 || core_reset !== 1'b1 || running !== 1'b0) begin tests_failed++; $display("FAIL wr_halt: got halt=%b rst=%b run=%b expected 1 1 0", halted, core_reset, running); end
        for (int j = 0; j < 4; j++) begin
            exp_mem[112+j] = tail[j];
            exp_mem[116+j] = 8'(32'hcafef00d >> (8*j));
        end
        pulse_start(1'b0, 1'b1, 1'b0);
        run_dump(1'b0, unstable, timeout, cycles);
        tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL wr_dump_timeout: got %b expected 0", timeout); end
        for (int j = 0; j < 4; j++) begin
            tests_run++; if (got[112+j] !== tail[j]) begin tests_failed++; $display("FAIL wr_byte[%0d]: got %h expected %h", 112+j, got[112+j], tail[j]); end
        end
        for (int j = 116; j < 120; j++) begin
            tests_run++; if (got[j] !== exp_mem[j]) begin tests_failed++; $display("FAIL wr_stop_byte[%0d]: got %h expected %h", j, got[j], exp_mem[j]); end
        end
    endtask

    task automatic test_dump_backpressure();
        int unstable, cycles;
        bit timeout;
        pulse_start(1'b0, 1'b1, 1'b0);
        tests_run++; if (bus.dump_valid_o !== 1'b1) begin tests_failed++; $display("FAIL bp_valid: got %b expected 1", bus.dump_valid_o); end
        run_dump(1'b1, unstable, timeout, cycles);
        tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL bp_timeout: got %b expected 0", timeout); end
        tests_run++; if (unstable != 0) begin tests_failed++; $display("FAIL bp_stable: got %0d changes expected 0", unstable); end
        for (int k = 0; k < 128; k++) begin
            tests_run++; if (got[k] !== exp_mem[k]) begin tests_failed++; $display("FAIL bp_byte[%0d]: got %h expected %h", k, got[k], exp_mem[k]); end
        end
    endtask

    task automatic test_mid_load_reset();
        int unstable, cycles;
        bit timeout;
        for (int k = 0; k < 10; k++) src[k] = 8'(8'he0 + k);
        pulse_start(1'b1, 1'b0, 1'b0);
        load_bytes(10);
        reset_ni = 1'b0;
        #1;
        tests_run++; if (bus.load_ready_o !== 1'b0 || bus.dump_valid_o !== 1'b0 || bus.dump_byte_o !== 8'h00) begin tests_failed++; $display("FAIL mr_stream: got ready=%b valid=%b byte=%h expected 0 0 00", bus.load_ready_o, bus.dump_valid_o, bus.dump_byte_o); end
        tests_run++; if (core_reset !== 1'b1 || running !== 1'b0 || halted !== 1'b0) begin tests_failed++; $display("FAIL mr_status: got rst=%b run=%b halt=%b expected 1 0 0", core_reset, running, halted); end
        step();
        reset_ni = 1'b1;
        step();
        pulse_start(1'b0, 1'b1, 1'b0);
        tests_run++; if (bus.dump_valid_o !== 1'b1) begin tests_failed++; $display("FAIL mr_idle_dump: got valid=%b expected 1", bus.dump_valid_o); end
        run_dump(1'b0, unstable, timeout, cycles);
        tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL mr_timeout: got %b expected 0", timeout); end
        for (int k = 0; k < 128; k++) begin
            tests_run++; if (got[k] !== exp_mem[k]) begin tests_failed++; $display("FAIL mr_byte[%0d]: got %h expected %h", k, got[k], exp_mem[k]); end
        end
    endtask

    task automatic test_ignored_requests();
        pulse_start(1'b1, 1'b1, 1'b0);
        tests_run++; if (bus.load_ready_o !== 1'b1 || bus.dump_valid_o !== 1'b0) begin tests_failed++; $display("FAIL ig_priority: got ready=%b valid=%b expected 1 0", bus.load_ready_o, bus.dump_valid_o); end
        pulse_start(1'b0, 1'b1, 1'b1);
        tests_run++; if (bus.load_ready_o !== 1'b1 || running !== 1'b0 || bus.dump_valid_o !== 1'b0) begin tests_failed++; $display("FAIL ig_in_load: got ready=%b run=%b valid=%b expected 1 0 0", bus.load_ready_o, running, bus.dump_valid_o); end
        for (int w = 0; w < 32; w++)
            for (int j = 0; j < 4; j++) src[4*w+j] = golden[w][8*j +: 8];
        load_bytes(128);
        tests_run++; if (running !== 1'b1 || core_reset !== 1'b1) begin tests_failed++; $display("FAIL ig_load_done: got run=%b rst=%b expected 1 1", running, core_reset); end
    endtask

    initial begin
        reset_ni         = 1'b0;
        core_clk_i       = 1'b0;
        core_addr        = 5'h00;
        core_rw          = 1'b0;
        tb_drive         = 1'b0;
        tb_wdata         = 32'h0;
        stop_lamp        = 1'b0;
        bus.load_start_i = 1'b0;
        bus.run_start_i  = 1'b0;
        bus.dump_start_i = 1'b0;
        bus.load_valid_i = 1'b0;
        bus.load_byte_i  = 8'h00;
        bus.dump_ready_i = 1'b0;
        for (int i = 0; i < 32; i++) begin
            logic [7:0] b;
            b = 8'(i);
            golden[i] = {b ^ 8'hc3, 8'(b * 8'd5), 8'hff - b, 8'(b * 8'd3 + 8'd1)};
        end
        golden[0]  = 32'h00000013;
        golden[1]  = 32'h0000401f;
        golden[31] = 32'h00000024;

        test_reset();
        test_load_dump_roundtrip();
        test_core_read();
        test_core_write_halt();
        test_dump_backpressure();
        test_mid_load_reset();
        test_ignored_requests();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
